// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for a single-port memory, with a bounded lock for
// atomic sequences and a fixed-latency read-return tag pipe that routes data back.
module mem_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic          clk,
  input  logic          reset_n_i,
  input  logic          m0_req_i,
  input  logic          m0_we_i,
  input  logic          m0_lock_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_wdata_i,
  output logic          m0_gnt_o,
  output logic          m0_rvalid_o,
  output logic [DW-1:0] m0_rdata_o,
  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic          m1_lock_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  output logic          m1_gnt_o,
  output logic          m1_rvalid_o,
  output logic [DW-1:0] m1_rdata_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam int unsigned   CW       = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);

  typedef enum logic [1:0] {ST_ARB, ST_LOCK0, ST_LOCK1} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_last, w_last_nxt;
  logic [CW-1:0]       r_lock_cnt, w_lock_cnt_nxt;
  logic [READ_LAT-1:0] r_tag_v, r_tag_p;
  logic                w_gnt0, w_gnt1, w_issue;

  // Grants are forced low while reset is asserted, independent of the clock.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (reset_n_i) begin
      case (r_state)
        ST_LOCK0: w_gnt0 = m0_req_i;
        ST_LOCK1: w_gnt1 = m1_req_i;
        default: begin
          if (m0_req_i && m1_req_i) begin
            w_gnt0 = r_last;
            w_gnt1 = !r_last;
          end else begin
            w_gnt0 = m0_req_i;
            w_gnt1 = m1_req_i;
          end
        end
      endcase
    end
  end

  assign w_issue     = w_gnt0 || w_gnt1;
  assign m0_gnt_o    = w_gnt0;
  assign m1_gnt_o    = w_gnt1;
  assign mem_en_o    = w_issue;
  assign mem_we_o    = w_gnt1 ? m1_we_i : (w_gnt0 ? m0_we_i : 1'b0);
  assign mem_addr_o  = w_gnt1 ? m1_addr_i : (w_gnt0 ? m0_addr_i : '0);
  assign mem_wdata_o = w_gnt1 ? m1_wdata_i : (w_gnt0 ? m0_wdata_i : '0);

  always_comb begin
    w_state_nxt    = r_state;
    w_last_nxt     = w_issue ? w_gnt1 : r_last;
    w_lock_cnt_nxt = r_lock_cnt;
    case (r_state)
      ST_ARB: begin
        if (w_gnt0 && m0_lock_i) begin
          w_state_nxt    = ST_LOCK0;
          w_lock_cnt_nxt = CW'(1);
        end else if (w_gnt1 && m1_lock_i) begin
          w_state_nxt    = ST_LOCK1;
          w_lock_cnt_nxt = CW'(1);
        end
      end
      ST_LOCK0: begin
        // Hitting the limit hands priority to the other port at the next contention.
        if (!m0_lock_i || r_lock_cnt == LOCK_MAX) begin
          w_state_nxt    = ST_ARB;
          w_lock_cnt_nxt = '0;
          if (m0_lock_i) w_last_nxt = 1'b0;
        end else begin
          w_lock_cnt_nxt = r_lock_cnt + CW'(1);
        end
      end
      ST_LOCK1: begin
        if (!m1_lock_i || r_lock_cnt == LOCK_MAX) begin
          w_state_nxt    = ST_ARB;
          w_lock_cnt_nxt = '0;
          if (m1_lock_i) w_last_nxt = 1'b1;
        end else begin
          w_lock_cnt_nxt = r_lock_cnt + CW'(1);
        end
      end
      default: w_state_nxt = ST_ARB;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= ST_ARB;
      r_last     <= 1'b1;
      r_lock_cnt <= '0;
      r_tag_v    <= '0;
      r_tag_p    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_tag_v[0] <= w_issue && !mem_we_o;
      r_tag_p[0] <= w_gnt1;
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        r_tag_v[i] <= r_tag_v[i-1];
        r_tag_p[i] <= r_tag_p[i-1];
      end
    end
  end

  assign m0_rvalid_o = r_tag_v[READ_LAT-1] && !r_tag_p[READ_LAT-1];
  assign m1_rvalid_o = r_tag_v[READ_LAT-1] && r_tag_p[READ_LAT-1];
  assign m0_rdata_o  = mem_rdata_i;
  assign m1_rdata_o  = mem_rdata_i;

endmodule
